// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, constants and helpers for the TX/RX paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;

   // Transmit frame states; explicit 3-bit encoding.
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP_1 = 3'd4,
      TX_STOP_2 = 3'd5
   } tx_state_t;

   // Source selector for the registered tx line.
   typedef enum logic [1:0] {
      TX_SEL_START  = 2'd0,
      TX_SEL_DATA   = 2'd1,
      TX_SEL_PARITY = 2'd2,
      TX_SEL_STOP   = 2'd3
   } tx_sel_t;

   // Parity bit for a byte: even parity when odd==0, odd parity when odd==1.
   function automatic logic parity_calc(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_controller
//  Description : UART transmit FSM. Sequences START/DATA/PARITY/STOP bits and
//                issues the load/shift/counter strobes and tx source select.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_controller
   import uart_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    tx_clk_en,
   input  logic    tx_queue_empty,
   input  logic    bit_end,
   input  logic    last_bit,
   input  logic    cfg_parity_en,
   input  logic    cfg_double_stop,
   output logic    load,
   output logic    shift,
   output logic    tick_clr,
   output logic    bit_cnt_en,
   output tx_sel_t tx_sel,
   output logic    busy,
   output logic    done
);

   tx_state_t r_state;
   tx_state_t w_state_next;
   logic      w_frame_end;

   // State register, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= TX_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; only advances on baud-enable edges.
   always_comb begin
      w_state_next = r_state;
      w_frame_end  = 1'b0;
      if (tx_clk_en) begin
         case (r_state)
            TX_IDLE: begin
               if (!tx_queue_empty) w_state_next = TX_START;
            end
            TX_START: begin
               if (bit_end) w_state_next = TX_DATA;
            end
            TX_DATA: begin
               if (bit_end && last_bit)
                  w_state_next = cfg_parity_en ? TX_PARITY : TX_STOP_1;
            end
            TX_PARITY: begin
               if (bit_end) w_state_next = TX_STOP_1;
            end
            TX_STOP_1: begin
               if (bit_end) begin
                  if (cfg_double_stop) begin
                     w_state_next = TX_STOP_2;
                  end else begin
                     w_frame_end  = 1'b1;
                     w_state_next = tx_queue_empty ? TX_IDLE : TX_START;
                  end
               end
            end
            TX_STOP_2: begin
               if (bit_end) begin
                  w_frame_end  = 1'b1;
                  w_state_next = tx_queue_empty ? TX_IDLE : TX_START;
               end
            end
            default: w_state_next = TX_IDLE;
         endcase
      end
   end

   // Control strobes; pops are suppressed while reset is asserted so an
   // abandoned frame never consumes a FIFO word.
   always_comb begin
      load       = reset && tx_clk_en && !tx_queue_empty &&
                   ((r_state == TX_IDLE) || w_frame_end);
      tick_clr   = load;
      shift      = reset && tx_clk_en && (r_state == TX_DATA) && bit_end;
      bit_cnt_en = shift;
      done       = reset && w_frame_end;
      busy       = (r_state != TX_IDLE);
      case (w_state_next)
         TX_START:  tx_sel = TX_SEL_START;
         TX_DATA:   tx_sel = TX_SEL_DATA;
         TX_PARITY: tx_sel = TX_SEL_PARITY;
         default:   tx_sel = TX_SEL_STOP;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter datapath: shift register, tick/bit counters,
//                latched frame config, parity accumulator and registered tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_clk_en,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  double_stop_bit,
   input  logic                  tx_queue_empty,
   input  logic [DATA_WIDTH-1:0] tx_queue_data,
   output logic                  tx_queue_re,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int c_tick_w = $clog2(OVERSAMPLE);
   localparam int c_bit_w  = $clog2(DATA_WIDTH + 1);

   logic [c_tick_w-1:0]   r_tick;
   logic [c_bit_w-1:0]    r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  r_parity;
   logic                  w_parity_next;
   logic                  r_cfg_parity_en;
   logic                  r_cfg_double_stop;
   logic                  r_tx;
   logic                  w_tx_next;
   logic                  w_bit_end;
   logic                  w_last_bit;
   logic                  w_load;
   logic                  w_shift;
   logic                  w_tick_clr;
   logic                  w_bit_cnt_en;
   logic                  w_busy;
   logic                  w_done;
   tx_sel_t               w_tx_sel;

   assign w_bit_end  = (r_tick == c_tick_w'(OVERSAMPLE - 1));
   assign w_last_bit = (r_bit_cnt == c_bit_w'(DATA_WIDTH - 1));

   uart_tx_controller u_ctrl (
      .clk             (clk),
      .reset           (reset),
      .tx_clk_en       (tx_clk_en),
      .tx_queue_empty  (tx_queue_empty),
      .bit_end         (w_bit_end),
      .last_bit        (w_last_bit),
      .cfg_parity_en   (r_cfg_parity_en),
      .cfg_double_stop (r_cfg_double_stop),
      .load            (w_load),
      .shift           (w_shift),
      .tick_clr        (w_tick_clr),
      .bit_cnt_en      (w_bit_cnt_en),
      .tx_sel          (w_tx_sel),
      .busy            (w_busy),
      .done            (w_done)
   );

   // Next shift/parity contents and the tx value for the upcoming bit. The
   // parity accumulator starts at parity_odd, so after the last data bit it
   // already holds the bit to transmit. parity_odd needs no separate latch.
   always_comb begin
      w_shift_next  = r_shift;
      w_parity_next = r_parity;
      if (w_load) begin
         w_shift_next  = tx_queue_data;
         w_parity_next = parity_odd;
      end else if (w_shift) begin
         w_shift_next  = {1'b0, r_shift[DATA_WIDTH-1:1]};
         w_parity_next = r_parity ^ r_shift[0];
      end
      case (w_tx_sel)
         TX_SEL_START:  w_tx_next = 1'b0;
         TX_SEL_DATA:   w_tx_next = w_shift_next[0];
         TX_SEL_PARITY: w_tx_next = w_parity_next;
         default:       w_tx_next = 1'b1;
      endcase
   end

   // Tick and bit counters; the tick counter wraps at OVERSAMPLE naturally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tick    <= '0;
         r_bit_cnt <= '0;
      end else if (tx_clk_en) begin
         if (w_tick_clr) begin
            r_tick    <= '0;
            r_bit_cnt <= '0;
         end else begin
            if (w_busy)       r_tick    <= r_tick + c_tick_w'(1);
            if (w_bit_cnt_en) r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
         end
      end
   end

   // Shift register, parity accumulator, frame config and tx line.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_shift           <= '0;
         r_parity          <= 1'b0;
         r_cfg_parity_en   <= 1'b0;
         r_cfg_double_stop <= 1'b0;
         r_tx              <= 1'b1;
      end else if (tx_clk_en) begin
         r_shift  <= w_shift_next;
         r_parity <= w_parity_next;
         r_tx     <= w_tx_next;
         if (w_load) begin
            r_cfg_parity_en   <= parity_en;
            r_cfg_double_stop <= double_stop_bit;
         end
      end
   end

   assign tx          = r_tx;
   assign tx_busy     = w_busy;
   assign tx_done     = w_done;
   assign tx_queue_re = w_load;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int DW = 8;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tx_clk_en = 1'b0;
   logic          parity_en = 1'b0;
   logic          parity_odd = 1'b0;
   logic          double_stop_bit = 1'b0;
   logic          tx_queue_empty = 1'b1;
   logic [DW-1:0] tx_queue_data = '0;
   logic          tx_queue_re;
   logic          tx;
   logic          tx_busy;
   logic          tx_done;

   uart_tx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
      .clk             (clk),
      .reset           (reset),
      .tx_clk_en       (tx_clk_en),
      .parity_en       (parity_en),
      .parity_odd      (parity_odd),
      .double_stop_bit (double_stop_bit),
      .tx_queue_empty  (tx_queue_empty),
      .tx_queue_data   (tx_queue_data),
      .tx_queue_re     (tx_queue_re),
      .tx              (tx),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] q[$];
   int en_div = 1;
   int en_cnt = 0;
   int pulse_cnt = 0;
   int cyc_cnt = 0;
   int pops = 0;
   int dones = 0;
   int bad_strobe = 0;
   int pop_at[16];
   int done_at[16];
   int pop_cyc[16];
   int done_cyc[16];
   bit pop_req = 1'b0;
   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // FIFO model and baud-enable generator; strobes are sampled 2ns into the
   // low phase, well before the rising edge that consumes them.
   always @(negedge clk) begin
      logic [DW-1:0] tmp;
      if (pop_req) begin
         if (q.size() > 0) tmp = q.pop_front();
         pop_req = 1'b0;
      end
      tx_queue_empty = (q.size() == 0);
      tx_queue_data  = (q.size() > 0) ? q[0] : '0;
      tx_clk_en      = ((en_cnt % en_div) == 0);
      en_cnt++;
      #2;
      cyc_cnt++;
      if (!tx_clk_en && (tx_queue_re || tx_done)) bad_strobe++;
      if (tx_clk_en) begin
         if (tx_queue_re) begin
            if (pops < 16) begin
               pop_at[pops]  = pulse_cnt;
               pop_cyc[pops] = cyc_cnt;
            end
            pops++;
            pop_req = 1'b1;
         end
         if (tx_done) begin
            if (dones < 16) begin
               done_at[dones]  = pulse_cnt;
               done_cyc[dones] = cyc_cnt;
            end
            dones++;
         end
         pulse_cnt++;
      end
   end

   task automatic push(input logic [DW-1:0] v);
      q.push_back(v);
      tx_queue_empty = 1'b0;
      tx_queue_data  = q[0];
   endtask

   task automatic wait_pulses(input int target, input string tag);
      int guard;
      guard = 0;
      while (pulse_cnt < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (pulse_cnt < target) check({tag, " timeout"}, pulse_cnt, target);
   endtask

   task automatic wait_pops(input int n, input string tag);
      int guard;
      guard = 0;
      while (pops < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (pops < n) check({tag, " pop timeout"}, pops, n);
   endtask

   task automatic wait_dones(input int n, input string tag);
      int guard;
      guard = 0;
      while (dones < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (dones < n) check({tag, " done timeout"}, dones, n);
   endtask

   // Checks every bit of frame idx mid-bit and the frame length in pulses.
   task automatic expect_frame(input int idx, input logic [DW-1:0] data, input logic pe,
                               input logic exp_par, input logic ds, input int flip_bit,
                               input string tag);
      logic [11:0] bits;
      int nbits;
      int p0;
      nbits = 10 + int'(pe) + int'(ds);
      bits  = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) bits[1+i] = data[i];
      if (pe) bits[9] = exp_par;
      wait_pops(idx + 1, tag);
      p0 = pop_at[idx];
      for (int b = 0; b < nbits; b++) begin
         wait_pulses(p0 + OS*b + OS/2 + 1, tag);
         if (b == flip_bit) parity_en = ~parity_en;
         check($sformatf("%s bit%0d", tag, b), tx, bits[b]);
      end
      wait_dones(idx + 1, tag);
      check({tag, " len"}, done_at[idx] - p0, OS*nbits);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst tx", tx, 1);
      check("rst busy", tx_busy, 0);
      check("rst done", tx_done, 0);
      check("rst re", tx_queue_re, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // 8N1, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
      push(8'hA5);
      expect_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, "8N1");
      repeat (20) @(negedge clk);
      check("8N1 idle tx", tx, 1);
      check("8N1 idle busy", tx_busy, 0);
      check("8N1 pops", pops, 1);

      // 8E2, 0xA5 has four ones -> parity 0, 192 pulses
      parity_en = 1'b1; parity_odd = 1'b0; double_stop_bit = 1'b1;
      push(8'hA5);
      expect_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1, -1, "8E2");

      // 8O1: 0x01 -> parity 0, 0x03 -> parity 1
      double_stop_bit = 1'b0; parity_odd = 1'b1;
      push(8'h01);
      expect_frame(2, 8'h01, 1'b1, 1'b0, 1'b0, -1, "8O1a");
      push(8'h03);
      expect_frame(3, 8'h03, 1'b1, 1'b1, 1'b0, -1, "8O1b");

      // Back-to-back 8N1
      parity_en = 1'b0; parity_odd = 1'b0;
      repeat (5) @(negedge clk);
      push(8'h55);
      push(8'h0F);
      expect_frame(4, 8'h55, 1'b0, 1'b0, 1'b0, -1, "b2b0");
      expect_frame(5, 8'h0F, 1'b0, 1'b0, 1'b0, -1, "b2b1");
      check("b2b gap", pop_at[5], done_at[4]);
      check("b2b pops", pops, 6);

      // Gated enable every 4th clk, parity_en toggled mid-frame
      repeat (5) @(negedge clk);
      en_div = 4;
      push(8'h3C);
      expect_frame(6, 8'h3C, 1'b0, 1'b0, 1'b0, 3, "gate");
      check("gate clks", done_cyc[6] - pop_cyc[6], 640);
      parity_en = 1'b0;
      en_div = 1;
      repeat (5) @(negedge clk);

      // Reset during data bit 3 (0x55 bit3 = 0)
      push(8'h55);
      push(8'h11);
      wait_pops(8, "rstmid");
      wait_pulses(pop_at[7] + OS*4 + 5, "rstmid");
      check("rstmid pre tx", tx, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rstmid tx", tx, 1);
      check("rstmid busy", tx_busy, 0);
      repeat (5) @(negedge clk);
      check("rstmid no pop", pops, 8);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("rstmid repop", pops, 9);
      check("rstmid start", tx, 0);
      wait_dones(8, "rstmid");
      check("rstmid len", done_at[7] - pop_at[8], OS*10);

      check("strobe gating", bad_strobe, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
